// File: rtl/spi_seq_pkg.sv
// Shared constants and the sequencer state type for the SPI command path.
package spi_seq_pkg;

    localparam int unsigned SPI_WORD_W         = 24;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_GAP_CYCLES     = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_END,
        GAP
    } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count == LW'(DEPTH));
        empty    = (count == '0);
        level    = count;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        pop_data = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues host SPI words, issues them one at a time to the SPI master and
// collects the received words into a response FIFO.
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 8,
    parameter int unsigned RSP_DEPTH      = 8,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset_in,
    input  logic [SPI_WORD_W-1:0]       cmd_data,
    input  logic                        cmd_strobe,
    output logic                        cmd_full,
    output logic [$clog2(CMD_DEPTH):0]  cmd_level,
    output logic                        spi_tx_start,
    output logic [SPI_WORD_W-1:0]       spi_tx_data,
    input  logic                        spi_tx_end,
    input  logic [SPI_WORD_W-1:0]       spi_rx_data,
    output logic [SPI_WORD_W-1:0]       rsp_data,
    output logic                        rsp_empty,
    input  logic                        rsp_read,
    output logic                        busy,
    output logic                        overflow_err,
    output logic                        timeout_err,
    input  logic                        clr_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned RSP_LW  = $clog2(RSP_DEPTH) + 1;

    seq_state_t              state;
    seq_state_t              state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    cmd_empty;
    logic                    cmd_pop;
    logic [SPI_WORD_W-1:0]   cmd_head;
    logic                    rsp_full;
    logic [RSP_LW-1:0]       rsp_level;
    logic                    rsp_push;
    logic                    launch;
    logic                    tmo_hit;
    logic                    gap_done;
    logic                    tmo_evt;
    logic                    ovf_evt;

    sync_fifo #(.WIDTH(SPI_WORD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset_in  (reset_in),
        .push      (cmd_strobe),
        .push_data (cmd_data),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .level     (cmd_level)
    );

    sync_fifo #(.WIDTH(SPI_WORD_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .reset_in  (reset_in),
        .push      (rsp_push),
        .push_data (spi_rx_data),
        .pop       (rsp_read),
        .pop_data  (rsp_data),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .level     (rsp_level)
    );

    always_comb begin
        launch   = !cmd_empty && (rsp_level < RSP_LW'(RSP_DEPTH));
        tmo_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        gap_done = (cnt == CNT_W'(GAP_CYCLES - 1));
        ovf_evt  = cmd_strobe && cmd_full;
    end

    always_ff @(posedge clk) begin
        if (reset_in) state <= IDLE;
        else          state <= state_nxt;
    end

    // The last gap cycle launches directly so back-to-back starts land
    // exactly GAP_CYCLES+1 cycles after the preceding end.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (launch) state_nxt = START;
            START:    state_nxt = WAIT_END;
            WAIT_END: if (spi_tx_end || tmo_hit) state_nxt = GAP;
            GAP:      if (gap_done) state_nxt = launch ? START : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_tx_start = (state == START);
        cmd_pop      = (state == START);
        busy         = (state != IDLE);
        rsp_push     = (state == WAIT_END) && spi_tx_end && !rsp_full;
        tmo_evt      = (state == WAIT_END) && !spi_tx_end && tmo_hit;
    end

    // Shared phase counter: restarts on every state change, idle in IDLE.
    always_ff @(posedge clk) begin
        if (reset_in || state == IDLE || state_nxt != state) cnt <= '0;
        else                                                  cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset_in)                spi_tx_data <= '0;
        else if (state_nxt == START) spi_tx_data <= cmd_head;
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (ovf_evt)      overflow_err <= 1'b1;
            else if (clr_err) overflow_err <= 1'b0;
            if (tmo_evt)      timeout_err  <= 1'b1;
            else if (clr_err) timeout_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a timestamp-based reference model.
module tb_spi_cmd_sequencer;

    localparam int CD   = 4;
    localparam int RD   = 4;
    localparam int GAP  = 3;
    localparam int TMO  = 40;
    localparam int DLY  = 5;
    localparam logic [23:0] MASK = 24'hB9F9B9;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [23:0] cmd_data;
    logic        cmd_strobe;
    logic        cmd_full;
    logic [2:0]  cmd_level;
    logic        spi_tx_start;
    logic [23:0] spi_tx_data;
    logic        spi_tx_end;
    logic [23:0] spi_rx_data;
    logic [23:0] rsp_data;
    logic        rsp_empty;
    logic        rsp_read;
    logic        busy;
    logic        overflow_err;
    logic        timeout_err;
    logic        clr_err;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(
        .CMD_DEPTH(CD), .RSP_DEPTH(RD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_in(reset_in), .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
        .cmd_full(cmd_full), .cmd_level(cmd_level), .spi_tx_start(spi_tx_start),
        .spi_tx_data(spi_tx_data), .spi_tx_end(spi_tx_end), .spi_rx_data(spi_rx_data),
        .rsp_data(rsp_data), .rsp_empty(rsp_empty), .rsp_read(rsp_read), .busy(busy),
        .overflow_err(overflow_err), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: queues for the FIFOs, timestamps for transfer phases.
    logic [23:0] cmdq[$];
    logic [23:0] rspq[$];
    bit          m_ok = 0;
    bit          m_active;
    int          m_start;
    int          m_done;
    logic [23:0] m_txdata;
    bit          m_ovf;
    bit          m_tmo;

    always @(posedge clk) begin : model_step
        int c; int csz; int rsz; bit go; bit ovf_ev; bit tmo_ev; bit push; logic [23:0] head;
        c = cyc;
        if (reset_in) begin
            cmdq.delete(); rspq.delete();
            m_active = 0; m_start = -1; m_done = -1000; m_txdata = '0;
            m_ovf = 0; m_tmo = 0; m_ok = 1;
        end else begin
            csz = cmdq.size();
            rsz = rspq.size();
            go = !m_active && (c >= m_done + GAP) && csz > 0 && rsz < RD;
            head = (csz > 0) ? cmdq[0] : '0;
            ovf_ev = cmd_strobe && (csz == CD);
            if (m_start == c) void'(cmdq.pop_front());
            if (cmd_strobe && !ovf_ev) cmdq.push_back(cmd_data);
            tmo_ev = 0; push = 0;
            if (m_active && c > m_start) begin
                if (spi_tx_end) begin push = 1; m_active = 0; m_done = c; end
                else if (c - m_start == TMO) begin tmo_ev = 1; m_active = 0; m_done = c; end
            end
            if (rsp_read && rsz > 0) void'(rspq.pop_front());
            if (push) rspq.push_back(spi_rx_data);
            if (ovf_ev) m_ovf = 1; else if (clr_err) m_ovf = 0;
            if (tmo_ev) m_tmo = 1; else if (clr_err) m_tmo = 0;
            if (go) begin m_active = 1; m_start = c + 1; m_txdata = head; end
        end
        cyc = c + 1;
    end

    int          st_cyc[$];
    logic [23:0] st_word[$];

    always @(negedge clk) begin
        if (m_ok) begin
            check("tx_start",  spi_tx_start, (m_start == cyc));
            check("tx_data",   spi_tx_data,  m_txdata);
            check("cmd_full",  cmd_full,     (cmdq.size() == CD));
            check("cmd_level", cmd_level,    cmdq.size());
            check("rsp_empty", rsp_empty,    (rspq.size() == 0));
            check("rsp_data",  rsp_data,     (rspq.size() > 0) ? rspq[0] : 24'h0);
            check("busy",      busy,         m_active || (cyc > m_done && cyc <= m_done + GAP));
            check("ovf_err",   overflow_err, m_ovf);
            check("tmo_err",   timeout_err,  m_tmo);
        end
        if (spi_tx_start === 1'b1) begin
            st_cyc.push_back(cyc);
            st_word.push_back(spi_tx_data);
        end
    end

    // SPI master stand-in: answers DLY cycles after each start unless stalled.
    bit stall    = 0;
    bit late_req = 0;

    initial begin : responder
        int cd; bit pending; logic [23:0] word;
        spi_tx_end = 1'b0; spi_rx_data = '0; pending = 0; cd = 0; word = '0;
        forever begin
            @(posedge clk); #1;
            spi_tx_end = 1'b0;
            if (late_req) begin
                spi_tx_end = 1'b1; spi_rx_data = 24'hDEAD00; late_req = 0;
            end else if (pending) begin
                if (cd == 1) begin spi_tx_end = 1'b1; spi_rx_data = word ^ MASK; pending = 0; end
                else cd--;
            end
            if (spi_tx_start === 1'b1 && !stall) begin pending = 1; cd = DLY; word = spi_tx_data; end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (st_cyc.size() < n && k < budget) begin tick(); k++; end
        check("start_count", st_cyc.size(), n);
    endtask

    initial begin : main
        int n0; int o; int k; bit found;
        logic [23:0] burst_rsp [3];
        burst_rsp = '{24'hB9F9B8, 24'hB9F9BB, 24'hB9F9BA};
        reset_in = 1'b1; cmd_data = '0; cmd_strobe = 1'b0; rsp_read = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        reset_in = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_rsp_empty", rsp_empty, 1);
        check("rst_cmd_level", cmd_level, 0);
        check("rst_tx_data", spi_tx_data, 0);
        check("rst_rsp_data", rsp_data, 0);
        repeat (2) tick();

        // single command: start two cycles after the strobe
        cmd_data = 24'h123456; cmd_strobe = 1'b1;
        tick(); cmd_strobe = 1'b0;
        check("single_n1_start", spi_tx_start, 0);
        tick();
        check("single_n2_start", spi_tx_start, 1);
        check("single_n2_data", spi_tx_data, 24'h123456);
        repeat (5) tick();
        check("single_rsp_before", rsp_empty, 1);
        tick();
        check("single_rsp_after", rsp_empty, 0);
        check("single_rsp_data", rsp_data, 24'hABCDEF);
        rsp_read = 1'b1;
        tick(); rsp_read = 1'b0;
        check("single_rsp_drained", rsp_empty, 1);
        repeat (6) tick();

        // burst of three
        n0 = st_cyc.size();
        for (int i = 0; i < 3; i++) begin cmd_data = 24'(i + 1); cmd_strobe = 1'b1; tick(); end
        cmd_strobe = 1'b0;
        check("burst_level", cmd_level, 2);
        wait_starts(n0 + 3, 100);
        if (st_cyc.size() >= n0 + 3) begin
            check("burst_space1", st_cyc[n0+1] - st_cyc[n0], DLY + GAP + 1);
            check("burst_space2", st_cyc[n0+2] - st_cyc[n0+1], DLY + GAP + 1);
            for (int i = 0; i < 3; i++) check("burst_word", st_word[n0+i], i + 1);
        end
        repeat (8) tick();
        for (int i = 0; i < 3; i++) begin
            check("burst_rsp", rsp_data, burst_rsp[i]);
            rsp_read = 1'b1; tick();
        end
        rsp_read = 1'b0;
        check("burst_drained", rsp_empty, 1);
        repeat (6) tick();

        // overflow with a stalled first transfer, which then times out
        stall = 1; n0 = st_cyc.size(); o = cyc;
        for (int i = 0; i < CD + 2; i++) begin cmd_data = 24'h100000 + 24'(i); cmd_strobe = 1'b1; tick(); end
        cmd_strobe = 1'b0;
        check("ovf_level", cmd_level, CD);
        check("ovf_full", cmd_full, 1);
        check("ovf_flag", overflow_err, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("ovf_cleared", overflow_err, 0);
        stall = 0;
        if (st_cyc.size() > n0) check("stall_start_cycle", st_cyc[n0], o + 2);
        while (cyc < o + 2 + TMO) tick();
        check("tmo_before", timeout_err, 0);
        clr_err = 1'b1; late_req = 1;
        tick(); clr_err = 1'b0;
        check("tmo_set_wins", timeout_err, 1);
        tick();
        check("late_end_ignored", rsp_empty, 1);
        wait_starts(n0 + 2, 20);
        if (st_cyc.size() >= n0 + 2) check("after_tmo_start", st_cyc[n0+1], o + 2 + TMO + GAP + 1);
        wait_starts(n0 + 5, 200);
        repeat (10) tick();
        found = 0;
        foreach (st_word[i]) if (st_word[i] == 24'h100005) found = 1;
        check("dropped_never_sent", found, 0);

        // response FIFO full: new command must wait for a read
        cmd_data = 24'h200006; cmd_strobe = 1'b1; tick(); cmd_strobe = 1'b0;
        repeat (20) tick();
        check("bp_no_start", st_cyc.size(), n0 + 5);
        check("bp_level", cmd_level, 1);
        check("bp_head", rsp_data, 24'hA9F9B8);
        rsp_read = 1'b1; tick(); rsp_read = 1'b0;
        wait_starts(n0 + 6, 20);
        if (st_cyc.size() >= n0 + 6) check("bp_word", st_word[n0+5], 24'h200006);
        repeat (10) tick();
        check("drain_head", rsp_data, 24'hA9F9BB);
        k = 0;
        while (rsp_empty == 1'b0 && k < 10) begin rsp_read = 1'b1; tick(); k++; end
        rsp_read = 1'b0;
        check("drain_count", k, 4);
        repeat (4) tick();

        // reset while waiting for the end of a transfer
        stall = 1; n0 = st_cyc.size();
        cmd_data = 24'h300001; cmd_strobe = 1'b1; tick();
        cmd_data = 24'h300002; tick(); cmd_strobe = 1'b0;
        repeat (3) tick();
        check("midrst_busy_before", busy, 1);
        reset_in = 1'b1; tick(); reset_in = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_rsp_empty", rsp_empty, 1);
        check("midrst_cmd_level", cmd_level, 0);
        check("midrst_start", spi_tx_start, 0);
        repeat (20) tick();
        check("midrst_no_restart", st_cyc.size(), n0 + 1);
        stall = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
